// File: rtl/ibuffer_queue.sv
// -----------------------------------------------------------------------------
// ibuffer_queue
//   Circular instruction buffer between the fetch unit and ctrlblock. Fetch
//   pushes one {inst, pc} per cycle, and ctrlblock pops one per cycle. Both
//   sides use valid/ready handshakes. A frontend redirect flushes every held
//   entry by resetting the pointers and the count.
//
//   Optional feature (macro IBUF_BYPASS_EN): when the buffer is empty, the
//   fetch entry is presented to ctrlblock in the same cycle.
//
// Ports
//   clock, reset_n       rising-edge clock, asynchronous active-low reset
//   ifu_valid/ifu_ready  fetch-side handshake
//   ifu_inst, ifu_pc     fetched entry
//   redirect_valid       flush request, which has priority over everything else
//   ibuffer_instr_valid  head entry valid toward ctrlblock
//   ibuffer_ready        ctrlblock consumes the head this cycle
//   ibuffer_inst_out/pc  head entry, or zero when not valid
//   ibuffer_count        number of entries currently held
// -----------------------------------------------------------------------------
module ibuffer_queue #(
  parameter int DEPTH  = 8,
  parameter int INST_W = 32,
  parameter int PC_W   = 48
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     ifu_valid,
  output logic                     ifu_ready,
  input  logic [INST_W-1:0]        ifu_inst,
  input  logic [PC_W-1:0]          ifu_pc,
  input  logic                     redirect_valid,
  output logic                     ibuffer_instr_valid,
  input  logic                     ibuffer_ready,
  output logic [INST_W-1:0]        ibuffer_inst_out,
  output logic [PC_W-1:0]          ibuffer_pc_out,
  output logic [$clog2(DEPTH):0]   ibuffer_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic [INST_W-1:0] mem_inst [DEPTH];
  logic [PC_W-1:0]   mem_pc   [DEPTH];

  logic held_valid;  // the stored head is presentable
  logic bypass;      // the fetch entry is presented directly (empty buffer)
  logic enq;
  logic deq;

  assign held_valid = (count != '0) && !redirect_valid;

  // Readiness depends only on occupancy. A dequeue in the same cycle does not
  // free a slot for fetch.
  assign ifu_ready = (count != CNT_W'(DEPTH)) && !redirect_valid;

`ifdef IBUF_BYPASS_EN
  assign bypass = (count == '0) && ifu_valid && !redirect_valid;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry that ctrlblock takes immediately is never written.
  assign enq = ifu_valid && ifu_ready && !(bypass && ibuffer_ready);
  assign deq = held_valid && ibuffer_ready;

  assign ibuffer_instr_valid = held_valid || bypass;
  assign ibuffer_count       = count;

  // NOTE: every output gets a default first, so this block cannot infer a latch.
  always_comb begin
    ibuffer_inst_out = '0;
    ibuffer_pc_out   = '0;
    if (held_valid) begin
      ibuffer_inst_out = mem_inst[rd_ptr];
      ibuffer_pc_out   = mem_pc[rd_ptr];
    end
`ifdef IBUF_BYPASS_EN
    else if (bypass) begin
      ibuffer_inst_out = ifu_inst;
      ibuffer_pc_out   = ifu_pc;
    end
`endif
  end

  // NOTE: state updates use non-blocking assignments, so all registers
  // sample pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;  // natural wrap DEPTH-1 -> 0
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset. Its entries are qualified by count,
  // and a redirect leaves stale data in place.
  always_ff @(posedge clock) begin
    if (enq) begin
      mem_inst[wr_ptr] <= ifu_inst;
      mem_pc[wr_ptr]   <= ifu_pc;
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(enq && count == CNT_W'(DEPTH)));
  a_no_underflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(deq && count == '0));

endmodule
